// File: rtl/r5p_bus_arb_if.sv
// r5p single-port bus: request fields from master, ready/read data back.
// Read data is valid the cycle after a read transfer.
interface r5p_bus_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic [DW-1:0] rdt;
  logic          rdy;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdt, rdy
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdt, rdy
  );
endinterface

// File: rtl/r5p_bus_arb.sv
// r5p 2:1 bus arbiter: IF and LS share one memory bus.
// Grant holds through stalls; read data returns to its owner.
module r5p_bus_arb #(
  parameter int    AW     = 32,
  parameter int    DW     = 32,
  parameter string POLICY = "FIXED",
  parameter int    STARVE = 8
) (
  input logic             clk,
  input logic             rst,
  r5p_bus_arb_if.slave    if_bus,
  r5p_bus_arb_if.slave    ls_bus,
  r5p_bus_arb_if.master   m_bus
);
  localparam bit RR    = (POLICY == "RR");
  localparam bit GUARD = !RR && (STARVE > 0);
  localparam int SW    = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE);

  typedef enum logic {
    P_IF = 1'b0,
    P_LS = 1'b1
  } port_e;

  port_e          sel;
  logic           req;
  logic           xfer;
  logic           starved;

  logic           lock_q, lock_d;
  port_e          lock_sel_q, lock_sel_d;
  port_e          prio_q, prio_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           rsp_vld_q, rsp_vld_d;
  port_e          rsp_sel_q, rsp_sel_d;
  logic [DW-1:0]  if_hold_q, if_hold_d;
  logic [DW-1:0]  ls_hold_q, ls_hold_d;

  always_comb begin
    starved = GUARD && if_bus.vld && (starve_q == SMAX);

    sel = P_LS;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (starved) begin
      sel = P_IF;
    end else if (if_bus.vld && ls_bus.vld) begin
      sel = RR ? prio_q : P_LS;
    end else if (if_bus.vld) begin
      sel = P_IF;
    end

    req  = (sel == P_LS) ? ls_bus.vld : if_bus.vld;
    xfer = req && m_bus.rdy;

    // A stalled request pins the grant until it completes.
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    if (xfer) begin
      lock_d = 1'b0;
    end else if (req) begin
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end

    prio_d = prio_q;
    if (RR && xfer) begin
      prio_d = (sel == P_IF) ? P_LS : P_IF;
    end

    starve_d = '0;
    if (GUARD && if_bus.vld && !(xfer && sel == P_IF)) begin
      starve_d = (starve_q == SMAX) ? starve_q : starve_q + SW'(1);
    end

    rsp_vld_d = xfer && !m_bus.wen;
    rsp_sel_d = sel;

    if_hold_d = if_hold_q;
    ls_hold_d = ls_hold_q;
    if (rsp_vld_q && rsp_sel_q == P_IF) begin
      if_hold_d = m_bus.rdt;
    end
    if (rsp_vld_q && rsp_sel_q == P_LS) begin
      ls_hold_d = m_bus.rdt;
    end
  end

  assign m_bus.vld = req;
  assign m_bus.wen = (sel == P_LS) ? ls_bus.wen : if_bus.wen;
  assign m_bus.adr = (sel == P_LS) ? ls_bus.adr : if_bus.adr;
  assign m_bus.ben = (sel == P_LS) ? ls_bus.ben : if_bus.ben;
  assign m_bus.wdt = (sel == P_LS) ? ls_bus.wdt : if_bus.wdt;

  assign if_bus.rdy = (sel == P_IF) && xfer;
  assign ls_bus.rdy = (sel == P_LS) && xfer;
  assign if_bus.rdt = if_hold_d;
  assign ls_bus.rdt = ls_hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_sel_q <= P_LS;
      prio_q     <= P_LS;
      starve_q   <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_sel_q  <= P_LS;
      if_hold_q  <= '0;
      ls_hold_q  <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      prio_q     <= prio_d;
      starve_q   <= starve_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_sel_q  <= rsp_sel_d;
      if_hold_q  <= if_hold_d;
      ls_hold_q  <= ls_hold_d;
    end
  end
endmodule
